serial_sub_4b: RTL
==================

SERIAL_SUB_4B -- requirements
Module: serial_sub_4b

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result bit count (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port bin  input  1  borrow-in; captured on accepted start.
REQ-008 SHALL have port diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-009 SHALL have port bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-010 SHALL have port busy  output  1  high while in SHIFT.
REQ-011 SHALL have port done  output  1  one-cycle pulse; diff/bout valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL go IDLE->SHIFT on an edge with start=1; at that edge it loads a, b, bin into internal shift registers, clears bit counter, and sets carry = ~bin.
REQ-014 SHALL, in SHIFT, process one bit per edge, LSB first: sum bit = a_i XOR ~b_i XOR carry; carry = majority(a_i, ~b_i, carry); sum bit shifted into the result register MSB side.
REQ-015 SHALL go SHIFT->DONE on the edge processing bit WIDTH-1; at that edge diff gets the full result and bout = ~final carry.
REQ-016 SHALL hold done=1 for exactly the one cycle spent in DONE, then go DONE->IDLE unconditionally.
REQ-017 SHALL give latency: done high in the WIDTH-th cycle after the start edge (cycle 4 for WIDTH=4).
REQ-018 SHALL ignore start while in SHIFT or DONE; no re-load, no queuing.
REQ-019 SHALL hold diff and bout stable from DONE until the next accepted start's SHIFT->DONE edge; they are not updated bit-by-bit on the ports.
REQ-020 SHALL ignore changes on a, b, bin after capture.
REQ-021 SHALL keep busy=1 in SHIFT only; busy and done are never high together.
REQ-022 SHALL accept a start in the IDLE cycle right after DONE, giving back-to-back throughput of one operation per WIDTH+1 cycles.

Reset
REQ-023 SHALL, on an edge with rst=1, force state IDLE, diff=0, bout=0, busy=0, done=0, counter=0, carry=0. rst has priority over start.
REQ-024 SHALL abort an in-flight operation on rst mid-SHIFT with no done pulse; diff/bout keep no partial result.

Structure
REQ-025 SHALL take the FSM state enum (IDLE/SHIFT/DONE) and the default WIDTH constant from a shared package, serial_arith_pkg.
REQ-026 SHALL instantiate the existing full_adder cell once as the per-bit datapath (a_i, ~b_i, carry -> sum, cout); no other sub-module.
REQ-027 SHALL size the bit counter as clog2(WIDTH) bits.

Verification
REQ-028 SHALL cover: a=9, b=3, bin=0, start pulse -> done in cycle 4, diff=6, bout=0, busy high cycles 1-3.
REQ-029 SHALL cover: a=3, b=9, bin=0 -> diff=10 (0xA), bout=1.
REQ-030 SHALL cover: a=0, b=0, bin=1 -> diff=15 (0xF), bout=1; then a=15, b=15, bin=0 -> diff=0, bout=0.
REQ-031 SHALL cover: start held high throughout, a/b changed during SHIFT -> first result from captured operands, second op starts in the IDLE cycle after done, done pulses every 5 cycles.
REQ-032 SHALL cover: rst asserted in cycle 2 of SHIFT -> next cycle IDLE, busy=0, diff=0, no done; a fresh a=7, b=2 op then gives diff=5, bout=0.
REQ-033 SHALL cover: exhaustive random check over all a, b, bin against a reference model of a - b - bin, with done asserted exactly once per accepted start.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Used as the per-bit datapath of the serial arithmetic units.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_sub_4b.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first.
// Computes a + ~b + ~bin through one full adder cell.
module serial_sub_4b
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic fa_a;
    logic fa_b;
    logic fa_c;
    logic fa_s;
    logic fa_co;

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // Sum bit enters on the MSB side; older bits move down.
    assign res_nxt = WIDTH'({fa_s, res} >> 1);

    // In IDLE the adder sees the live inputs so bit 0 (carry-in
    // ~bin) resolves on the start edge; SHIFT then needs only
    // WIDTH-1 cycles, giving one operation per WIDTH+1 cycles.
    always_comb begin
        fa_a = a_sh[0];
        fa_b = ~b_sh[0];
        fa_c = carry;
        if (state == ST_IDLE) begin
            fa_a = a[0];
            fa_b = ~b[0];
            fa_c = ~bin;
        end
    end

    full_adder u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_c),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Control FSM, operand shifters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a >> 1;
                        b_sh  <= b >> 1;
                        res   <= {fa_s, {(WIDTH-1){1'b0}}};
                        carry <= fa_co;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_nxt;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= res_nxt;
                        bout  <= ~fa_co;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
